uart_rx_engine: RTL and testbench

UART_RX_ENGINE -- requirements
Module: uart_rx_engine

---
 rtl/uart_rx_engine_if.sv | 27 ++
 rtl/uart_rx_engine.sv | 251 +++++++++++++++++++++++++
 tb/tb_uart_rx_engine.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_engine_if.sv
// Received-word handshake bundle between the UART receive engine and its consumer.
// The engine drives the word and its status flags, the consumer drives rx_ready.
interface uart_rx_engine_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  parity_err;
    logic                  frame_err;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_engine.sv
// Oversampled UART receiver with runtime-configurable framing and a valid/ready output register.
// Defining UART_RX_BREAK_DETECT_EN adds break_det and suppresses delivery of all-zero frames.
module uart_rx_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx,
    input  logic                    tick_os,
    input  logic [1:0]              data_bits_cfg,
    input  logic [1:0]              parity_cfg,
    input  logic                    stop_cfg,
    input  logic                    msb_first,
    uart_rx_engine_if.master        out_if,
    output logic                    overrun_err,
    output logic                    busy
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                    break_det
`endif
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic [2:0] state_q, state_d;
    logic [CW-1:0] tick_q, tick_d;
    logic [3:0] bit_q, bit_d, nbits_q, nbits_d, cfg_nbits, idx;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [1:0] par_mode_q, par_mode_d;
    logic stop2_q, stop2_d, msb_q, msb_d;
    logic par_acc_q, par_acc_d, perr_q, perr_d, ferr_q, ferr_d;
    logic stop_idx_q, stop_idx_d;
    logic fall, sample, done, ferr_now;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic valid_q, valid_d, operr_q, operr_d, oferr_q, oferr_d;
    logic overrun_q, overrun_d, accept;
`ifdef UART_RX_BREAK_DETECT_EN
    logic zero_q, zero_d, zero_now, brk_q, brk_d;
`endif

    assign fall = rx_prev_q & ~rx_sync_q;

    // Width code 3 means 9 bits only on a 9-bit build; never exceed the data register.
    always_comb begin
        case (data_bits_cfg)
            2'd0:    cfg_nbits = 4'd5;
            2'd1:    cfg_nbits = 4'd6;
            2'd2:    cfg_nbits = 4'd7;
            default: cfg_nbits = (DATA_WIDTH == 9) ? 4'd9 : 4'd8;
        endcase
        if (cfg_nbits > 4'(DATA_WIDTH)) cfg_nbits = 4'(DATA_WIDTH);
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        nbits_d    = nbits_q;
        par_mode_d = par_mode_q;
        stop2_d    = stop2_q;
        msb_d      = msb_q;
        par_acc_d  = par_acc_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        stop_idx_d = stop_idx_q;
        done       = 1'b0;
        ferr_now   = ferr_q | ~rx_sync_q;
`ifdef UART_RX_BREAK_DETECT_EN
        zero_d     = zero_q;
        zero_now   = zero_q & ~rx_sync_q;
        brk_d      = 1'b0;
`endif
        idx    = msb_q ? (nbits_q - 4'd1 - bit_q) : bit_q;
        sample = tick_os && (tick_q == ((state_q == S_START) ? HALF_M1 : FULL_M1));
        if (tick_os && state_q != S_IDLE && state_q != S_BREAK)
            tick_d = sample ? '0 : tick_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    state_d    = S_START;
                    tick_d     = '0;
                    bit_d      = 4'd0;
                    shift_d    = '0;
                    nbits_d    = cfg_nbits;
                    par_mode_d = parity_cfg;
                    stop2_d    = stop_cfg;
                    msb_d      = msb_first;
                    par_acc_d  = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    stop_idx_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d     = 1'b1;
`endif
                end
            end
            S_START: begin
                if (sample) state_d = rx_sync_q ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (sample) begin
                    for (int i = 0; i < DATA_WIDTH; i++)
                        if (idx == 4'(i)) shift_d[i] = rx_sync_q;
                    par_acc_d = par_acc_q ^ rx_sync_q;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d    = zero_now;
`endif
                    bit_d     = bit_q + 4'd1;
                    if (bit_q == nbits_q - 4'd1)
                        state_d = (par_mode_q == 2'd1 || par_mode_q == 2'd2) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (sample) begin
                    perr_d  = (par_mode_q == 2'd1) ? ~(par_acc_q ^ rx_sync_q)
                                                   :  (par_acc_q ^ rx_sync_q);
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d  = zero_now;
`endif
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (sample) begin
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                        ferr_d     = ferr_now;
`ifdef UART_RX_BREAK_DETECT_EN
                        zero_d     = zero_now;
`endif
                    end else begin
                        state_d = S_IDLE;
                        done    = 1'b1;
`ifdef UART_RX_BREAK_DETECT_EN
                        // A line held low through the whole frame is a break, not a word.
                        if (zero_now) begin
                            state_d = S_BREAK;
                            done    = 1'b0;
                            brk_d   = 1'b1;
                        end
`endif
                    end
                end
            end
            S_BREAK: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A completing frame may load only if the register is empty or being drained this cycle.
    always_comb begin
        accept    = valid_q & out_if.rx_ready;
        data_d    = data_q;
        valid_d   = valid_q;
        operr_d   = operr_q;
        oferr_d   = oferr_q;
        overrun_d = 1'b0;
        if (done) begin
            if (!valid_q || accept) begin
                data_d  = shift_q;
                valid_d = 1'b1;
                operr_d = perr_q;
                oferr_d = ferr_now;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= S_IDLE;
            tick_q     <= '0;
            bit_q      <= 4'd0;
            shift_q    <= '0;
            nbits_q    <= 4'd0;
            par_mode_q <= 2'd0;
            stop2_q    <= 1'b0;
            msb_q      <= 1'b0;
            par_acc_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_idx_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            operr_q    <= 1'b0;
            oferr_q    <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q     <= 1'b0;
            brk_q      <= 1'b0;
`endif
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            nbits_q    <= nbits_d;
            par_mode_q <= par_mode_d;
            stop2_q    <= stop2_d;
            msb_q      <= msb_d;
            par_acc_q  <= par_acc_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            stop_idx_q <= stop_idx_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            operr_q    <= operr_d;
            oferr_q    <= oferr_d;
            overrun_q  <= overrun_d;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q     <= zero_d;
            brk_q      <= brk_d;
`endif
        end
    end

    assign out_if.rx_data    = data_q;
    assign out_if.rx_valid   = valid_q;
    assign out_if.parity_err = operr_q;
    assign out_if.frame_err  = oferr_q;
    assign overrun_err       = overrun_q;
    assign busy              = (state_q != S_IDLE);
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det         = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed testbench for uart_rx_engine: framing variants, glitch, overrun, break and mid-frame reset.
// Build with or without UART_RX_BREAK_DETECT_EN; the break scenario adapts its expectations.
module tb_uart_rx_engine;

    localparam int BIT_CLKS = 32;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       tick_os;
    logic [1:0] data_bits_cfg;
    logic [1:0] parity_cfg;
    logic       stop_cfg;
    logic       msb_first;
    logic       overrun_err;
    logic       busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       break_det;
`endif

    int vectors = 0;
    int miscompares = 0;
    int valid_seen = 0;
    int overrun_seen = 0;
    int brk_seen = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_perr = 1'b0;
    logic       last_ferr = 1'b0;

    uart_rx_engine_if #(.DATA_WIDTH(8)) out_if ();

    uart_rx_engine #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx),
        .tick_os       (tick_os),
        .data_bits_cfg (data_bits_cfg),
        .parity_cfg    (parity_cfg),
        .stop_cfg      (stop_cfg),
        .msb_first     (msb_first),
        .out_if        (out_if),
        .overrun_err   (overrun_err),
        .busy          (busy)
`ifdef UART_RX_BREAK_DETECT_EN
        ,
        .break_det     (break_det)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample enable: one clk high out of every two, so one bit lasts 32 clks.
    initial begin
        tick_os = 1'b0;
        forever @(negedge clk) tick_os = ~tick_os;
    end

    always @(negedge clk) begin
        if (out_if.rx_valid) begin
            valid_seen <= valid_seen + 1;
            last_data  <= out_if.rx_data;
            last_perr  <= out_if.parity_err;
            last_ferr  <= out_if.frame_err;
        end
        if (overrun_err) overrun_seen <= overrun_seen + 1;
`ifdef UART_RX_BREAK_DETECT_EN
        if (break_det) brk_seen <= brk_seen + 1;
`endif
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [1:0] bits, input logic [1:0] par, input logic stop, input logic msb);
        data_bits_cfg = bits;
        parity_cfg    = par;
        stop_cfg      = stop;
        msb_first     = msb;
    endtask

    task automatic send_frame(input logic [8:0] word, input int nbits, input logic msb,
                              input logic has_par, input logic par_bit,
                              input int nstops, input logic last_stop);
        send_bit(1'b0);
        for (int k = 0; k < nbits; k++)
            send_bit(msb ? word[nbits-1-k] : word[k]);
        if (has_par) send_bit(par_bit);
        for (int s = 0; s < nstops; s++)
            send_bit((s == nstops - 1) ? last_stop : 1'b1);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        out_if.rx_ready = 1'b1;
        set_cfg(2'd3, 2'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        if (out_if.rx_data !== 8'h00) begin $display("[TB] FAIL reset_rx_data: got %h, expected 00", out_if.rx_data); miscompares++; end
        vectors++;
        if (out_if.rx_valid !== 1'b0) begin $display("[TB] FAIL reset_rx_valid: got %b, expected 0", out_if.rx_valid); miscompares++; end
        vectors++;
        if (out_if.parity_err !== 1'b0) begin $display("[TB] FAIL reset_parity_err: got %b, expected 0", out_if.parity_err); miscompares++; end
        vectors++;
        if (out_if.frame_err !== 1'b0) begin $display("[TB] FAIL reset_frame_err: got %b, expected 0", out_if.frame_err); miscompares++; end
        vectors++;
        if (overrun_err !== 1'b0) begin $display("[TB] FAIL reset_overrun_err: got %b, expected 0", overrun_err); miscompares++; end
        vectors++;
        if (busy !== 1'b0) begin $display("[TB] FAIL reset_busy: got %b, expected 0", busy); miscompares++; end
        vectors++;
`ifdef UART_RX_BREAK_DETECT_EN
        if (break_det !== 1'b0) begin $display("[TB] FAIL reset_break_det: got %b, expected 0", break_det); miscompares++; end
        vectors++;
`endif
        rst_n = 1'b1;
        idle_bits(1);
    endtask

    task automatic test_8n1();
        int v0;
        set_cfg(2'd3, 2'd0, 1'b0, 1'b0);
        v0 = valid_seen;
        send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(1);
        if (valid_seen - v0 !== 1) begin $display("[TB] FAIL 8n1_valid_cycles: got %0d, expected 1", valid_seen - v0); miscompares++; end
        vectors++;
        if (last_data !== 8'hA5) begin $display("[TB] FAIL 8n1_data: got %h, expected a5", last_data); miscompares++; end
        vectors++;
        if (last_perr !== 1'b0 || last_ferr !== 1'b0) begin
            $display("[TB] FAIL 8n1_errors: got perr=%b ferr=%b, expected 0 0", last_perr, last_ferr); miscompares++;
        end
        vectors++;
        if (busy !== 1'b0) begin $display("[TB] FAIL 8n1_busy_after: got %b, expected 0", busy); miscompares++; end
        vectors++;
    endtask

    task automatic test_parity();
        // 7E2 MSB-first, 0x55 has four ones, parity bit 1 makes the total odd.
        set_cfg(2'd2, 2'd2, 1'b1, 1'b1);
        send_frame(9'h055, 7, 1'b1, 1'b1, 1'b1, 2, 1'b1);
        idle_bits(1);
        if (last_data !== 8'h55) begin $display("[TB] FAIL 7e2_data: got %h, expected 55", last_data); miscompares++; end
        vectors++;
        if (last_perr !== 1'b1) begin $display("[TB] FAIL 7e2_parity_err: got %b, expected 1", last_perr); miscompares++; end
        vectors++;
        if (last_ferr !== 1'b0) begin $display("[TB] FAIL 7e2_frame_err: got %b, expected 0", last_ferr); miscompares++; end
        vectors++;
        // 8O1 LSB-first 0x07 (three ones) with parity 0 is correct odd parity.
        set_cfg(2'd3, 2'd1, 1'b0, 1'b0);
        send_frame(9'h007, 8, 1'b0, 1'b1, 1'b0, 1, 1'b1);
        idle_bits(1);
        if (last_data !== 8'h07 || last_perr !== 1'b0) begin
            $display("[TB] FAIL 8o1_good: got data=%h perr=%b, expected 07 0", last_data, last_perr); miscompares++;
        end
        vectors++;
        send_frame(9'h007, 8, 1'b0, 1'b1, 1'b1, 1, 1'b1);
        idle_bits(1);
        if (last_perr !== 1'b1) begin $display("[TB] FAIL 8o1_bad_parity_err: got %b, expected 1", last_perr); miscompares++; end
        vectors++;
    endtask

    task automatic test_frame_err();
        set_cfg(2'd3, 2'd0, 1'b0, 1'b0);
        send_frame(9'h081, 8, 1'b0, 1'b0, 1'b0, 1, 1'b0);
        idle_bits(1);
        if (last_data !== 8'h81 || last_ferr !== 1'b1) begin
            $display("[TB] FAIL 8n1_stop0: got data=%h ferr=%b, expected 81 1", last_data, last_ferr); miscompares++;
        end
        vectors++;
        // 5N2 with only the second stop bit low; upper bits of rx_data must read zero.
        set_cfg(2'd0, 2'd3, 1'b1, 1'b0);
        send_frame(9'h00B, 5, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        idle_bits(1);
        if (last_data !== 8'h0B || last_ferr !== 1'b1 || last_perr !== 1'b0) begin
            $display("[TB] FAIL 5n2_stop2: got data=%h ferr=%b perr=%b, expected 0b 1 0", last_data, last_ferr, last_perr); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_glitch();
        int v0;
        set_cfg(2'd3, 2'd0, 1'b0, 1'b0);
        v0 = valid_seen;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        if (busy !== 1'b1) begin $display("[TB] FAIL glitch_busy_rise: got %b, expected 1", busy); miscompares++; end
        vectors++;
        repeat (40) @(negedge clk);
        if (busy !== 1'b0) begin $display("[TB] FAIL glitch_busy_fall: got %b, expected 0", busy); miscompares++; end
        vectors++;
        idle_bits(1);
        if (valid_seen - v0 !== 0) begin $display("[TB] FAIL glitch_no_valid: got %0d, expected 0", valid_seen - v0); miscompares++; end
        vectors++;
    endtask

    task automatic test_overrun();
        int o0;
        set_cfg(2'd3, 2'd0, 1'b0, 1'b0);
        out_if.rx_ready = 1'b0;
        o0 = overrun_seen;
        send_frame(9'h011, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(1);
        send_frame(9'h022, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(1);
        if (out_if.rx_valid !== 1'b1 || out_if.rx_data !== 8'h11) begin
            $display("[TB] FAIL overrun_held: got valid=%b data=%h, expected 1 11", out_if.rx_valid, out_if.rx_data); miscompares++;
        end
        vectors++;
        if (overrun_seen - o0 !== 1) begin $display("[TB] FAIL overrun_pulses: got %0d, expected 1", overrun_seen - o0); miscompares++; end
        vectors++;
        out_if.rx_ready = 1'b1;
        @(negedge clk);
        if (out_if.rx_valid !== 1'b0) begin $display("[TB] FAIL overrun_drain: got valid=%b, expected 0", out_if.rx_valid); miscompares++; end
        vectors++;
    endtask

    task automatic test_break();
        int v0;
        int b0;
        set_cfg(2'd3, 2'd0, 1'b0, 1'b0);
        v0 = valid_seen;
        b0 = brk_seen;
        rx = 1'b0;
        repeat (12 * BIT_CLKS) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
        if (busy !== 1'b1) begin $display("[TB] FAIL break_busy_hold: got %b, expected 1", busy); miscompares++; end
        vectors++;
`else
        if (busy !== 1'b0) begin $display("[TB] FAIL break_busy_idle: got %b, expected 0", busy); miscompares++; end
        vectors++;
`endif
        idle_bits(1);
        if (busy !== 1'b0) begin $display("[TB] FAIL break_busy_after: got %b, expected 0", busy); miscompares++; end
        vectors++;
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk_seen - b0 !== 1) begin $display("[TB] FAIL break_pulses: got %0d, expected 1", brk_seen - b0); miscompares++; end
        vectors++;
        if (valid_seen - v0 !== 0) begin $display("[TB] FAIL break_no_valid: got %0d, expected 0", valid_seen - v0); miscompares++; end
        vectors++;
`else
        if (valid_seen - v0 !== 1 || last_data !== 8'h00 || last_ferr !== 1'b1) begin
            $display("[TB] FAIL break_as_frame: got valid=%0d data=%h ferr=%b, expected 1 00 1",
                     valid_seen - v0, last_data, last_ferr); miscompares++;
        end
        vectors++;
        if (brk_seen - b0 !== 0) begin $display("[TB] FAIL break_no_pulse: got %0d, expected 0", brk_seen - b0); miscompares++; end
        vectors++;
`endif
    endtask

    task automatic test_reset_mid();
        int v0;
        set_cfg(2'd3, 2'd0, 1'b0, 1'b0);
        out_if.rx_ready = 1'b0;
        send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(1);
        if (out_if.rx_valid !== 1'b1 || out_if.rx_data !== 8'h5A) begin
            $display("[TB] FAIL midrst_pending: got valid=%b data=%h, expected 1 5a", out_if.rx_valid, out_if.rx_data); miscompares++;
        end
        vectors++;
        send_bit(1'b0);
        for (int k = 0; k < 3; k++) send_bit(1'b1);
        rx = 1'b1;
        repeat (BIT_CLKS / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        if (out_if.rx_valid !== 1'b0 || out_if.rx_data !== 8'h00 || busy !== 1'b0) begin
            $display("[TB] FAIL midrst_outputs: got valid=%b data=%h busy=%b, expected 0 00 0",
                     out_if.rx_valid, out_if.rx_data, busy); miscompares++;
        end
        vectors++;
        if (out_if.parity_err !== 1'b0 || out_if.frame_err !== 1'b0 || overrun_err !== 1'b0) begin
            $display("[TB] FAIL midrst_flags: got perr=%b ferr=%b ovr=%b, expected 0 0 0",
                     out_if.parity_err, out_if.frame_err, overrun_err); miscompares++;
        end
        vectors++;
        rst_n = 1'b1;
        out_if.rx_ready = 1'b1;
        idle_bits(7);
        v0 = valid_seen;
        send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b0, 1, 1'b1);
        idle_bits(1);
        if (valid_seen - v0 !== 1 || last_data !== 8'h3C || last_ferr !== 1'b0) begin
            $display("[TB] FAIL midrst_next_frame: got valid=%0d data=%h ferr=%b, expected 1 3c 0",
                     valid_seen - v0, last_data, last_ferr); miscompares++;
        end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_break();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
